// File: rtl/uart_alu_cmd_ctrl.sv
// uart_alu_cmd_ctrl: byte-command controller between a UART and an NB_DATA-wide ALU.
// Optional ACK/NAK replies are compiled in when UART_ALU_CMD_ACK_EN is defined.
module uart_alu_cmd_ctrl #(
   parameter int unsigned NB_BYTE        = 8,
   parameter int unsigned NB_DATA        = 16,
   parameter int unsigned NB_ALU_OP      = 6,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [NB_BYTE-1:0]   i_rx_data,
   input  logic                 i_rx_done,
   input  logic                 i_tx_done,
   input  logic [NB_DATA-1:0]   i_alu_res,
   output logic                 o_tx_start,
   output logic [NB_BYTE-1:0]   o_tx_data,
   output logic [NB_ALU_OP-1:0] o_alu_op,
   output logic [NB_DATA-1:0]   o_alu_a,
   output logic [NB_DATA-1:0]   o_alu_b,
   output logic                 o_busy,
   output logic                 o_err
);

   localparam int unsigned NBYTES = NB_DATA / NB_BYTE;
   localparam int unsigned CNT_W  = $clog2(NBYTES + 1);
   localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [NB_BYTE-1:0] OP_GET_RES    = NB_BYTE'(8'h00);
   localparam logic [NB_BYTE-1:0] OP_SET_A      = NB_BYTE'(8'h01);
   localparam logic [NB_BYTE-1:0] OP_SET_B      = NB_BYTE'(8'h02);
   localparam logic [NB_BYTE-1:0] OP_SET_OP     = NB_BYTE'(8'h03);
   localparam logic [NB_BYTE-1:0] OP_GET_STATUS = NB_BYTE'(8'h04);
`ifdef UART_ALU_CMD_ACK_EN
   localparam logic [NB_BYTE-1:0] BYTE_ACK      = NB_BYTE'(8'h06);
   localparam logic [NB_BYTE-1:0] BYTE_NAK      = NB_BYTE'(8'h15);
`endif

   typedef enum logic [1:0] {IDLE, RECV, LOAD_TX, WAIT_TX} state_e;
   typedef enum logic [1:0] {TGT_A, TGT_B, TGT_OP} target_e;

   state_e               state_q, state_d;
   target_e              tgt_q, tgt_d;
   logic [NB_DATA-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [TMO_W-1:0]     tmo_q, tmo_d;
   logic [NB_DATA-1:0]   alu_a_q, alu_a_d;
   logic [NB_DATA-1:0]   alu_b_q, alu_b_d;
   logic [NB_ALU_OP-1:0] alu_op_q, alu_op_d;
   logic                 tx_start_q, tx_start_d;
   logic [NB_BYTE-1:0]   tx_data_q, tx_data_d;
   logic                 timeout_flag_q, timeout_flag_d;
   logic                 bad_op_flag_q, bad_op_flag_d;
   logic                 tmo_set, bad_set, flag_clr;
   logic                 last_byte;
   logic [NB_DATA-1:0]   rx_shift;

   // Incoming bytes enter at the top so the first byte ends up in the LSBs.
   assign rx_shift  = (shift_q >> NB_BYTE) | (NB_DATA'(i_rx_data) << (NB_DATA - NB_BYTE));
   assign last_byte = (tgt_q == TGT_OP) || (cnt_q == CNT_W'(NBYTES - 1));

   always_comb begin
      state_d    = state_q;
      tgt_d      = tgt_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_op_d   = alu_op_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      tmo_set    = 1'b0;
      bad_set    = 1'b0;
      flag_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_rx_done) begin
               cnt_d = '0;
               tmo_d = '0;
               case (i_rx_data)
                  OP_SET_A:  begin tgt_d = TGT_A;  state_d = RECV; end
                  OP_SET_B:  begin tgt_d = TGT_B;  state_d = RECV; end
                  OP_SET_OP: begin tgt_d = TGT_OP; state_d = RECV; end
                  OP_GET_RES: begin
                     shift_d = i_alu_res;
                     cnt_d   = CNT_W'(NBYTES);
                     state_d = LOAD_TX;
                  end
                  OP_GET_STATUS: begin
                     shift_d  = NB_DATA'({timeout_flag_q, bad_op_flag_q});
                     cnt_d    = CNT_W'(1);
                     flag_clr = 1'b1;
                     state_d  = LOAD_TX;
                  end
                  default: begin
                     bad_set = 1'b1;
`ifdef UART_ALU_CMD_ACK_EN
                     shift_d = NB_DATA'(BYTE_NAK);
                     cnt_d   = CNT_W'(1);
                     state_d = LOAD_TX;
`endif
                  end
               endcase
            end
         end
         RECV: begin
            if (i_rx_done) begin
               shift_d = rx_shift;
               tmo_d   = '0;
               if (last_byte) begin
                  case (tgt_q)
                     TGT_A:   alu_a_d  = rx_shift;
                     TGT_B:   alu_b_d  = rx_shift;
                     default: alu_op_d = i_rx_data[NB_ALU_OP-1:0];
                  endcase
`ifdef UART_ALU_CMD_ACK_EN
                  shift_d = NB_DATA'(BYTE_ACK);
                  cnt_d   = CNT_W'(1);
                  state_d = LOAD_TX;
`else
                  state_d = IDLE;
`endif
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               tmo_set = 1'b1;
               shift_d = '0;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         LOAD_TX: begin
            tx_start_d = 1'b1;
            tx_data_d  = shift_q[NB_BYTE-1:0];
            state_d    = WAIT_TX;
         end
         WAIT_TX: begin
            if (i_tx_done) begin
               shift_d = shift_q >> NB_BYTE;
               cnt_d   = cnt_q - CNT_W'(1);
               state_d = (cnt_q > CNT_W'(1)) ? LOAD_TX : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A flag event coinciding with a status read keeps the flag set.
      timeout_flag_d = (timeout_flag_q & ~flag_clr) | tmo_set;
      bad_op_flag_d  = (bad_op_flag_q & ~flag_clr) | bad_set;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q        <= IDLE;
         tgt_q          <= TGT_A;
         shift_q        <= '0;
         cnt_q          <= '0;
         tmo_q          <= '0;
         alu_a_q        <= '0;
         alu_b_q        <= '0;
         alu_op_q       <= '0;
         tx_start_q     <= 1'b0;
         tx_data_q      <= '0;
         timeout_flag_q <= 1'b0;
         bad_op_flag_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         tgt_q          <= tgt_d;
         shift_q        <= shift_d;
         cnt_q          <= cnt_d;
         tmo_q          <= tmo_d;
         alu_a_q        <= alu_a_d;
         alu_b_q        <= alu_b_d;
         alu_op_q       <= alu_op_d;
         tx_start_q     <= tx_start_d;
         tx_data_q      <= tx_data_d;
         timeout_flag_q <= timeout_flag_d;
         bad_op_flag_q  <= bad_op_flag_d;
      end
   end

   assign o_tx_start = tx_start_q;
   assign o_tx_data  = tx_data_q;
   assign o_alu_op   = alu_op_q;
   assign o_alu_a    = alu_a_q;
   assign o_alu_b    = alu_b_q;
   assign o_busy     = (state_q != IDLE);
   assign o_err      = timeout_flag_q | bad_op_flag_q;

endmodule

// File: tb/tb_uart_alu_cmd_ctrl.sv
// tb_uart_alu_cmd_ctrl: protocol-level reference model, UART tx responder and
// directed plus randomized command streams for uart_alu_cmd_ctrl.
module tb_uart_alu_cmd_ctrl;

   localparam int TMO = 50;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [7:0]  i_rx_data;
   logic        i_rx_done;
   logic        i_tx_done;
   logic [15:0] i_alu_res;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic [5:0]  o_alu_op;
   logic [15:0] o_alu_a;
   logic [15:0] o_alu_b;
   logic        o_busy;
   logic        o_err;

   logic [15:0] noise = '0;

   uart_alu_cmd_ctrl #(
      .NB_BYTE(8),
      .NB_DATA(16),
      .NB_ALU_OP(6),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_rx_data(i_rx_data),
      .i_rx_done(i_rx_done),
      .i_tx_done(i_tx_done),
      .i_alu_res(i_alu_res),
      .o_tx_start(o_tx_start),
      .o_tx_data(o_tx_data),
      .o_alu_op(o_alu_op),
      .o_alu_a(o_alu_a),
      .o_alu_b(o_alu_b),
      .o_busy(o_busy),
      .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [5:0] op);
      return (op == 6'h20) ? a + b : a ^ b;
   endfunction

   // Stand-in ALU; noise lets the bench move the result under a transmission.
   assign i_alu_res = alu_f(o_alu_a, o_alu_b, o_alu_op) ^ noise;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state, kept at command level.
   logic [15:0] m_a, m_b, m_acc;
   logic [5:0]  m_op;
   logic        m_tf, m_bf;
   int          m_tgt, m_nb, m_gap;
   logic [7:0]  exp_q[$];
   logic [7:0]  got_q[$];

   task automatic model_reset();
      m_a = '0; m_b = '0; m_op = '0; m_tf = 1'b0; m_bf = 1'b0;
      m_tgt = -1; m_nb = 0; m_acc = '0; m_gap = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic [15:0] res;
      logic        done;
      done = 1'b0;
      if (m_tgt < 0) begin
         case (b)
            8'h00: begin
               res = alu_f(m_a, m_b, m_op) ^ noise;
               exp_q.push_back(res[7:0]);
               exp_q.push_back(res[15:8]);
            end
            8'h01, 8'h02, 8'h03: begin m_tgt = int'(b); m_nb = 0; m_acc = '0; end
            8'h04: begin
               exp_q.push_back({6'b0, m_tf, m_bf});
               m_tf = 1'b0; m_bf = 1'b0;
            end
            default: begin
               m_bf = 1'b1;
`ifdef UART_ALU_CMD_ACK_EN
               exp_q.push_back(8'h15);
`endif
            end
         endcase
      end else if (m_tgt == 3) begin
         m_op = b[5:0];
         done = 1'b1;
      end else begin
         m_acc[m_nb*8 +: 8] = b;
         m_nb++;
         if (m_nb == 2) begin
            if (m_tgt == 1) m_a = m_acc; else m_b = m_acc;
            done = 1'b1;
         end
      end
      if (done) begin
         m_tgt = -1;
`ifdef UART_ALU_CMD_ACK_EN
         exp_q.push_back(8'h06);
`endif
      end
      m_gap = 0;
   endtask

   // UART transmitter stand-in: records bytes, answers with tx_done after 0..3 cycles.
   logic tx_busy = 1'b0;
   logic prev_start = 1'b0;
   int   tx_wait = 0;
   initial begin
      i_tx_done = 1'b0;
      forever begin
         @(negedge i_clk);
         i_tx_done = 1'b0;
         if (o_tx_start === 1'b1) begin
            got_q.push_back(o_tx_data);
            total++;
            if (tx_busy || prev_start) begin
               bad++;
               $display("FAIL tx_pacing: got tx_start while busy=%0d prev=%0d want idle", tx_busy, prev_start);
            end
            tx_busy = 1'b1;
            tx_wait = $urandom_range(0, 3);
         end
         prev_start = o_tx_start;
         if (tx_busy) begin
            if (tx_wait == 0) begin i_tx_done = 1'b1; tx_busy = 1'b0; end
            else tx_wait--;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      i_rx_data = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         m_gap++;
         if (m_tgt >= 0 && m_gap == TMO) begin m_tgt = -1; m_tf = 1'b1; end
      end
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((o_busy || tx_busy) && k < 300) begin
         @(negedge i_clk);
         k++;
      end
      if (k >= 300) begin
         total++; bad++;
         $display("FAIL wait_idle: got busy after %0d cycles want idle", k);
      end
   endtask

   task automatic do_byte(input logic [7:0] b);
      model_byte(b);
      send_byte(b);
      if (m_tgt < 0) wait_idle();
   endtask

   task automatic set16(input logic [7:0] op, input logic [15:0] v);
      do_byte(op);
      do_byte(v[7:0]);
      do_byte(v[15:8]);
   endtask

   task automatic check_tx(input string name);
      chk($sformatf("%s_len", name), got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_b%0d", name, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_regs(input string name);
      chk($sformatf("%s_a", name), o_alu_a, m_a);
      chk($sformatf("%s_b", name), o_alu_b, m_b);
      chk($sformatf("%s_op", name), o_alu_op, m_op);
      chk($sformatf("%s_err", name), o_err, m_tf | m_bf);
      chk($sformatf("%s_busy", name), o_busy, m_tgt >= 0);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [5:0]  op;
      logic [15:0] res;
   } vec_t;

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish by 900000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[4];
      int   k;
      tbl[0] = '{16'h0005, 16'h0003, 6'h20, 16'h0008};
      tbl[1] = '{16'hFFFF, 16'h0001, 6'h20, 16'h0000};
      tbl[2] = '{16'h1234, 16'h00FF, 6'h11, 16'h12CB};
      tbl[3] = '{16'hA5A5, 16'h5A5A, 6'h01, 16'hFFFF};

      i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = '0;
      model_reset();
      repeat (3) @(negedge i_clk);
      chk("rst_tx_start", o_tx_start, 0);
      chk("rst_tx_data", o_tx_data, 0);
      check_regs("rst");
      i_reset = 1'b0;
      @(negedge i_clk);

      // Operand A must not expose the half-loaded value.
      do_byte(8'h01);
      do_byte(8'h34);
      chk("seta_partial", o_alu_a, 16'h0000);
      do_byte(8'h12);
      chk("seta_commit", o_alu_a, 16'h1234);
      check_tx("seta_tx");

      foreach (tbl[i]) begin
         set16(8'h01, tbl[i].a);
         set16(8'h02, tbl[i].b);
         do_byte(8'h03);
         do_byte({2'b00, tbl[i].op});
         check_tx($sformatf("tbl%0d_set", i));
         do_byte(8'h00);
         chk($sformatf("tbl%0d_len", i), got_q.size(), 2);
         if (got_q.size() == 2) chk($sformatf("tbl%0d_res", i), {got_q[1], got_q[0]}, tbl[i].res);
         check_tx($sformatf("tbl%0d_model", i));
         check_regs($sformatf("tbl%0d", i));
      end

      // Timeout discards the partial operand and sets the timeout flag.
      do_byte(8'h02);
      do_byte(8'hAA);
      idle(60);
      chk("tmo_b", o_alu_b, 16'h5A5A);
      chk("tmo_err", o_err, 1);
      do_byte(8'h04);
      chk("tmo_status", got_q.size() > 0 ? got_q[0] : 8'hEE, 8'h02);
      check_tx("tmo_status_model");
      chk("tmo_err_clr", o_err, 0);

      // Boundary: one idle cycle short of the limit still accepts the byte.
      do_byte(8'h02); do_byte(8'h11); idle(TMO - 1); do_byte(8'h22);
      chk("tmo_edge_ok_b", o_alu_b, 16'h2211);
      chk("tmo_edge_ok_err", o_err, 0);
      do_byte(8'h02); do_byte(8'h33); idle(TMO); do_byte(8'h44);
      check_regs("tmo_edge_hit");
      do_byte(8'h04);
      check_tx("tmo_edge_status");

      do_byte(8'h7F);
      chk("badop_err", o_err, 1);
      check_tx("badop_tx");
      do_byte(8'h04);
      check_tx("badop_status");
      check_regs("badop");

      // Snapshot and dropped byte during GET_RES.
      noise = 16'h5A3C;
      model_byte(8'h00);
      send_byte(8'h00);
      k = 0;
      while (got_q.size() == 0 && k < 50) begin @(negedge i_clk); k++; end
      chk("drop_first_tx", k < 50, 1);
      noise = 16'hFFFF;
      send_byte(8'h01);
      wait_idle();
      check_tx("drop_res");
      check_regs("drop");
      do_byte(8'h04);
      check_tx("drop_status");
      noise = '0;

      // Reset between the two data bytes of SET_B.
      do_byte(8'h02);
      do_byte(8'h11);
      i_reset = 1'b1;
      @(negedge i_clk);
      i_reset = 1'b0;
      model_reset();
      chk("midrst_tx_start", o_tx_start, 0);
      chk("midrst_tx_data", o_tx_data, 0);
      check_regs("midrst");
      set16(8'h02, 16'h3322);
      check_regs("postrst");
      check_tx("postrst_tx");

      for (int n = 0; n < 200; n++) begin
         int unsigned r;
         logic [7:0]  opb, d;
         r = $urandom_range(0, 9);
         noise = 16'($urandom);
         case (r)
            0, 1:    opb = 8'h00;
            2, 8:    opb = 8'h01;
            3, 4:    opb = 8'h02;
            5:       opb = 8'h03;
            6:       opb = 8'h04;
            default: opb = 8'($urandom_range(5, 255));
         endcase
         do_byte(opb);
         if (opb >= 8'h01 && opb <= 8'h03) begin
            for (int j = 0; j < ((opb == 8'h03) ? 1 : 2); j++) begin
               idle(($urandom_range(0, 19) == 0) ? $urandom_range(TMO, TMO + 10)
                                                 : $urandom_range(0, 4));
               d = 8'($urandom);
               do_byte(d);
            end
         end
         check_tx($sformatf("rnd%0d", n));
         check_regs($sformatf("rnd%0d", n));
      end
      idle(TMO + 2);
      wait_idle();
      do_byte(8'h04);
      check_tx("final_status");
      check_regs("final");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_alu_cmd_ctrl.md
Name: uart_alu_cmd_ctrl

Overview:
- Command controller between the UART (rx/tx byte streams) and a parametrised-width ALU.
- Decodes a byte-oriented command protocol and loads multi-byte operands A/B atomically, plus the ALU opcode.
- Returns the multi-byte ALU result over UART, paced by the transmitter's done handshake.
- Adds receive timeout, bad-opcode detection and a readable sticky status byte.

Parameters:
- NB_BYTE, 8, UART byte width.
- NB_DATA, 16, ALU operand/result width; must be an integer multiple of NB_BYTE; NBYTES = NB_DATA/NB_BYTE, NBYTES ≥ 1.
- NB_ALU_OP, 6, ALU opcode width; must be ≤ NB_BYTE.
- TIMEOUT_CYCLES, 100000, maximum idle clocks allowed between bytes of a multi-byte command.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_BYTE  received byte; valid when i_rx_done = 1.
- i_rx_done  in  1  one-cycle pulse: byte received.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_alu_res  in  NB_DATA  ALU result.
- o_tx_start  out  1  one-cycle pulse: start transmitting o_tx_data.
- o_tx_data  out  NB_BYTE  byte to transmit; held until the next o_tx_start.
- o_alu_op  out  NB_ALU_OP  ALU opcode register.
- o_alu_a  out  NB_DATA  operand A register.
- o_alu_b  out  NB_DATA  operand B register.
- o_busy  out  1  1 whenever the state is not IDLE.
- o_err  out  1  OR of the sticky status flags.

Behaviour:
- Reset: state IDLE; all outputs 0; shift register, byte counter, timeout counter and flags cleared. Reset mid-command aborts the command with no partial commit.
- Opcodes:
  - 0x00 GET_RES: send NBYTES bytes of the result.
  - 0x01 SET_A: receive NBYTES bytes.
  - 0x02 SET_B: receive NBYTES bytes.
  - 0x03 SET_OP: receive 1 byte.
  - 0x04 GET_STATUS: send 1 status byte.
  - Any other opcode: set bad_op, stay in IDLE, transmit nothing.
- States: IDLE, RECV, LOAD_TX, WAIT_TX.
- IDLE:
  - rx_done with a SET opcode → RECV; byte count = 0, timeout counter = 0.
  - GET_RES → snapshot i_alu_res into the tx shift register at that edge, then → LOAD_TX.
  - GET_STATUS → load {(NB_BYTE-2) zeros, timeout_flag, bad_op_flag}, clear both flags at that edge, then → LOAD_TX.
- RECV:
  - Each rx_done shifts the byte in, LSB-first (first byte = bits [NB_BYTE-1:0]), and resets the timeout counter.
  - On the final byte, the target register updates on that same edge (SET_OP takes i_rx_data[NB_ALU_OP-1:0]); → IDLE.
  - o_alu_a and o_alu_b never show partially loaded values.
  - Timeout counter reaching TIMEOUT_CYCLES-1 with no rx_done → discard the partial value, set timeout_flag, → IDLE.
- LOAD_TX: register o_tx_start = 1 and o_tx_data = current low byte; → WAIT_TX. o_tx_start is high for exactly one cycle.
- WAIT_TX:
  - i_tx_done → shift the tx register right by NB_BYTE and decrement remaining.
  - remaining > 0 → LOAD_TX; otherwise → IDLE.
  - A tx_done arriving in the same cycle as o_tx_start is still honoured.
- Latency: command rx_done at edge k → o_tx_start high for the cycle after edge k+1 (two edges).
- i_rx_done in LOAD_TX or WAIT_TX: byte dropped, no state change. i_tx_done outside WAIT_TX is ignored.
- The result is snapshotted once per GET_RES; ALU changes during transmission do not affect the bytes sent.
- Flags are sticky until GET_STATUS or reset. A flag event in the same cycle as a GET_STATUS clear wins (the flag stays set).

Optional Feature:
- Macro: UART_ALU_CMD_ACK_EN.
- Defined: after every SET commit, load byte 0x06 (ACK) → LOAD_TX → WAIT_TX → IDLE, so o_busy covers the ACK transfer. A bad opcode sends 0x15 (NAK) in addition to setting bad_op.
- Undefined: SET commands and bad opcodes are silent; the ACK/NAK logic is absent.

Test Plan (NB_DATA = 16, TIMEOUT_CYCLES = 50 in bench):
- Send 0x01, 0x34, 0x12 → o_alu_a stays 0x0000 after 0x34; o_alu_a = 0x1234 on the edge of the 0x12 rx_done.
- Send SET_A 0x0005, SET_B 0x0003, SET_OP 0x20; ALU model returns 0x0008; send 0x00 → o_tx_start pulses twice, bytes 0x08 then 0x00, each pulse after an i_tx_done.
- Send 0x02, 0xAA, then 60 idle cycles → o_alu_b unchanged, o_err = 1; send 0x04 → tx byte 0x02, then o_err = 0.
- Send 0x7F → no tx, o_err = 1; send 0x04 → tx byte 0x01. With UART_ALU_CMD_ACK_EN defined: 0x15 is sent before the status byte.
- During GET_RES transmission, inject rx_done 0x01 → byte dropped, state returns to IDLE, o_alu_a unchanged.
- Assert i_reset between the two data bytes of SET_B → all outputs 0, o_busy = 0; the next command decodes normally.
